// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding,
// control-bit positions and default per-stage widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_WB_EN     = 2;

  localparam int PIPE_CTRL_W    = 3;
  localparam int ID_EXE_DATA_W  = 104;
  localparam int EXE_MEM_DATA_W = 72;
  localparam int MEM_WB_DATA_W  = 68;

  function automatic logic [1:0] occupancy_of(input pipe_state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// freeze (stall), flush and bubble suppression of the control field.
module pipe_stage_reg #(
  parameter int DATA_W  = 72,
  parameter int CTRL_W  = 3,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  import pipe_pkg::*;

  pipe_state_e       state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;

  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && !freeze;

  generate
    if (SKID_EN) begin : g_skid
      // Registered decode only: no path from out_ready to in_ready.
      assign in_ready = (state != ST_FULL) && !freeze;
    end else begin : g_single
      assign in_ready = (!out_valid || out_ready) && !freeze;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            state     <= ST_FULL;
          end else if (out_fire && !in_fire) begin
            state <= ST_EMPTY;
          end else if (in_fire && out_fire) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= ST_BUSY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Bubbles present a zero control field so downstream needs no valid gating.
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign occupancy = occupancy_of(state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic against
// a queue-based model, on both the skid and single-entry variants.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [71:0] d;
    logic [2:0]  c;
  } ent_t;

  logic        clk;
  logic        rst, freeze, flush, out_ready;
  logic        in_valid, in_valid0;
  logic [71:0] in_data;
  logic [2:0]  in_ctrl;

  logic        o1_in_ready, o1_valid, o0_in_ready, o0_valid;
  logic [71:0] o1_data, o0_data;
  logic [2:0]  o1_ctrl, o0_ctrl;
  logic [1:0]  o1_occ, o0_occ;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t q1[$], q0[$];
  ent_t h1, h0;

  pipe_stage_reg #(.DATA_W(72), .CTRL_W(3), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(o1_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o1_valid), .out_ready(out_ready), .out_data(o1_data), .out_ctrl(o1_ctrl),
    .occupancy(o1_occ)
  );

  pipe_stage_reg #(.DATA_W(72), .CTRL_W(3), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid0), .in_ready(o0_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o0_valid), .out_ready(out_ready), .out_data(o0_data), .out_ctrl(o0_ctrl),
    .occupancy(o0_occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic exp_ready1();
    return (q1.size() < 2) && !freeze;
  endfunction

  function automatic logic exp_ready0();
    return ((q0.size() == 0) || out_ready) && !freeze;
  endfunction

  // Advance one clock; the model decides transfers from pre-edge inputs.
  task automatic tick();
    logic f1_in, f1_out, f0_in, f0_out;
    ent_t e;
    f1_in  = in_valid && exp_ready1();
    f1_out = (q1.size() != 0) && out_ready && !freeze;
    f0_in  = in_valid0 && exp_ready0();
    f0_out = (q0.size() != 0) && out_ready && !freeze;
    e = '{d: in_data, c: in_ctrl};
    @(posedge clk);
    if (!rst) begin
      q1.delete(); q0.delete();
      h1 = '0; h0 = '0;
    end else if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (f1_out) void'(q1.pop_front());
      if (f1_in) q1.push_back(e);
      if (f0_out) void'(q0.pop_front());
      if (f0_in) q0.push_back(e);
      if (q1.size() != 0) h1 = q1[0];
      if (q0.size() != 0) h0 = q0[0];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_valid0 = 1'b1; in_data = 72'h3C; in_ctrl = 3'b111;
    tick(); tick();
    n_checks += 4;
    if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", o1_valid); end
    if (o1_data !== 72'h0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", o1_data); end
    if (o1_ctrl !== 3'b0 || o0_ctrl !== 3'b0) begin n_fail++; $display("FAIL reset_ctrl got %0b/%0b exp 0", o1_ctrl, o0_ctrl); end
    if (o1_occ !== 2'd0 || o0_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d/%0d exp 0", o1_occ, o0_occ); end
    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
    #1;
    n_checks++;
    if (o1_in_ready !== 1'b1 || o0_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b/%0b exp 1", o1_in_ready, o0_in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 72'hA5; in_ctrl = 3'b101;
    #1; tick();
    in_valid = 1'b0;
    #1;
    n_checks += 3;
    if (o1_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b exp 1", o1_valid); end
    if (o1_data !== 72'hA5 || o1_ctrl !== 3'b101) begin n_fail++; $display("FAIL single_payload got %0h/%0b exp a5/101", o1_data, o1_ctrl); end
    if (o1_occ !== 2'd1) begin n_fail++; $display("FAIL single_occ1 got %0d exp 1", o1_occ); end
    tick();
    n_checks += 2;
    if (o1_occ !== 2'd0 || o1_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got occ %0d valid %0b exp 0/0", o1_occ, o1_valid); end
    if (o1_ctrl !== 3'b0) begin n_fail++; $display("FAIL single_bubble_ctrl got %0b exp 0", o1_ctrl); end
  endtask

  task automatic test_backpressure();
    logic [71:0] seq[4];
    logic [71:0] got[$];
    int idx;
    seq = '{72'd1, 72'd2, 72'd3, 72'd4};
    in_ctrl = 3'b010;
    out_ready = 1'b1; in_valid = 1'b1; in_data = seq[0];
    #1; tick();
    out_ready = 1'b0; in_data = seq[1];
    #1; tick();
    in_data = seq[2];
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks += 3;
      if (o1_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ got %0d exp 2", o1_occ); end
      if (o1_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b exp 0", o1_in_ready); end
      if (o1_data !== 72'd1) begin n_fail++; $display("FAIL bp_stable got %0d exp 1", o1_data); end
      tick();
    end
    out_ready = 1'b1;
    idx = 2;
    for (int k = 0; k < 20 && got.size() < 4; k++) begin
      in_valid = (idx < 4);
      if (idx < 4) in_data = seq[idx];
      #1;
      if (o1_valid) got.push_back(o1_data);
      if (in_valid && o1_in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (got.size() != 4) begin n_fail++; $display("FAIL bp_count got %0d exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_checks++;
      if (got[i] !== seq[i]) begin n_fail++; $display("FAIL bp_order idx %0d got %0d exp %0d", i, got[i], seq[i]); end
    end
  endtask

  task automatic test_freeze();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 72'd7; in_ctrl = 3'b100;
    #1; tick();
    out_ready = 1'b1; freeze = 1'b1; in_data = 72'd99;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks += 3;
      if (o1_valid !== 1'b1 || o1_data !== 72'd7) begin n_fail++; $display("FAIL freeze_hold got %0b/%0d exp 1/7", o1_valid, o1_data); end
      if (o1_in_ready !== 1'b0) begin n_fail++; $display("FAIL freeze_in_ready got %0b exp 0", o1_in_ready); end
      if (o1_occ !== 2'd1) begin n_fail++; $display("FAIL freeze_occ got %0d exp 1", o1_occ); end
      tick();
    end
    freeze = 1'b0; in_valid = 1'b0;
    #1; tick();
    n_checks++;
    if (o1_valid !== 1'b0 || o1_occ !== 2'd0) begin n_fail++; $display("FAIL freeze_release got %0b/%0d exp 0/0", o1_valid, o1_occ); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b111;
    in_data = 72'd8; #1; tick();
    in_data = 72'd9; #1; tick();
    in_data = 72'd10; flush = 1'b1; freeze = 1'b1;
    #1;
    n_checks++;
    if (o1_occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d exp 2", o1_occ); end
    tick();
    flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    #1;
    n_checks += 4;
    if (o1_valid !== 1'b0 || o1_ctrl !== 3'b0) begin n_fail++; $display("FAIL flush_out got %0b/%0b exp 0/0", o1_valid, o1_ctrl); end
    if (o1_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d exp 0", o1_occ); end
    if (o1_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0b exp 1", o1_in_ready); end
    if (o1_data !== 72'd8) begin n_fail++; $display("FAIL flush_data_hold got %0d exp 8", o1_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak got valid %0b data %0d exp 0", o1_valid, o1_data); end
    end
    in_valid = 1'b1; in_data = 72'd11; flush = 1'b1;
    #1; tick();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    n_checks++;
    if (o1_occ !== 2'd0 || o1_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_drop got occ %0d rdy %0b exp 0/1", o1_occ, o1_in_ready); end
  endtask

  task automatic test_throughput();
    logic [71:0] got[$];
    int first, last;
    first = -1; last = -1;
    out_ready = 1'b1; in_valid = 1'b0; in_ctrl = 3'b001;
    for (int k = 0; k <= 16; k++) begin
      in_valid0 = (k < 16);
      in_data = 72'(100 + k);
      #1;
      if (k < 16) begin
        n_checks++;
        if (o0_in_ready !== 1'b1) begin n_fail++; $display("FAIL tput_in_ready cycle %0d got %0b exp 1", k, o0_in_ready); end
      end
      if (o0_valid) begin
        got.push_back(o0_data);
        if (first < 0) first = k;
        last = k;
      end
      tick();
    end
    in_valid0 = 1'b0;
    n_checks += 2;
    if (got.size() != 16) begin n_fail++; $display("FAIL tput_count got %0d exp 16", got.size()); end
    if (first != 1 || last != 16) begin n_fail++; $display("FAIL tput_window got %0d..%0d exp 1..16", first, last); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_checks++;
      if (got[i] !== 72'(100 + i)) begin n_fail++; $display("FAIL tput_order idx %0d got %0d exp %0d", i, got[i], 100 + i); end
    end
    in_valid0 = 1'b1; in_data = 72'd200;
    #1; tick();
    in_valid0 = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (o0_in_ready !== 1'b0) begin n_fail++; $display("FAIL single_comb_low got %0b exp 0", o0_in_ready); end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (o0_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_comb_high got %0b exp 1", o0_in_ready); end
    tick();
  endtask

  task automatic test_random();
    ent_t x1, x0;
    logic v;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 99) < 65);
      in_valid = v; in_valid0 = v;
      in_data = {8'($urandom()), $urandom(), $urandom()};
      in_ctrl = 3'($urandom());
      out_ready = ($urandom_range(0, 99) < 60);
      freeze = ($urandom_range(0, 99) < 10);
      flush = ($urandom_range(0, 99) < 4);
      rst = !($urandom_range(0, 99) < 2);
      #1;
      x1 = (q1.size() != 0) ? q1[0] : '{d: h1.d, c: 3'b0};
      x0 = (q0.size() != 0) ? q0[0] : '{d: h0.d, c: 3'b0};
      n_checks += 10;
      if (o1_valid !== (q1.size() != 0)) begin n_fail++; $display("FAIL rnd1_valid cyc %0d got %0b exp %0b", k, o1_valid, q1.size() != 0); end
      if (o1_data !== x1.d) begin n_fail++; $display("FAIL rnd1_data cyc %0d got %0h exp %0h", k, o1_data, x1.d); end
      if (o1_ctrl !== x1.c) begin n_fail++; $display("FAIL rnd1_ctrl cyc %0d got %0b exp %0b", k, o1_ctrl, x1.c); end
      if (o1_occ !== 2'(q1.size())) begin n_fail++; $display("FAIL rnd1_occ cyc %0d got %0d exp %0d", k, o1_occ, q1.size()); end
      if (o1_in_ready !== exp_ready1()) begin n_fail++; $display("FAIL rnd1_in_ready cyc %0d got %0b exp %0b", k, o1_in_ready, exp_ready1()); end
      if (o0_valid !== (q0.size() != 0)) begin n_fail++; $display("FAIL rnd0_valid cyc %0d got %0b exp %0b", k, o0_valid, q0.size() != 0); end
      if (o0_data !== x0.d) begin n_fail++; $display("FAIL rnd0_data cyc %0d got %0h exp %0h", k, o0_data, x0.d); end
      if (o0_ctrl !== x0.c) begin n_fail++; $display("FAIL rnd0_ctrl cyc %0d got %0b exp %0b", k, o0_ctrl, x0.c); end
      if (o0_occ !== 2'(q0.size())) begin n_fail++; $display("FAIL rnd0_occ cyc %0d got %0d exp %0d", k, o0_occ, q0.size()); end
      if (o0_in_ready !== exp_ready0()) begin n_fail++; $display("FAIL rnd0_in_ready cyc %0d got %0b exp %0b", k, o0_in_ready, exp_ready0()); end
      tick();
    end
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
  endtask

  initial begin
    h1 = '0; h0 = '0;
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_valid0 = 1'b0; in_data = '0; in_ctrl = '0;
    #2;
    test_reset();
    test_single();
    test_backpressure();
    test_freeze();
    test_flush();
    test_throughput();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
